// File: rtl/conv_layer_sequencer_if.sv
// Bus bundle between the convolution-layer sequencer and its environment:
// frame control, input-buffer read port and featuremap-bank stream.
interface conv_layer_sequencer_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 14
);
  // Frame control
  logic                  start;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic                  err;
  // Input buffer read port
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  // Featuremap bank stream
  logic [DATA_WIDTH-1:0] fm_data;
  logic                  fm_valid;
  logic [6:0]            fm_col;
  logic [6:0]            fm_row;
  logic                  fm_valid_out;

  // Sequencer side
  modport slave (
    input  start, hold, rd_data, fm_valid_out,
    output busy, done, err, rd_en, rd_addr, fm_data, fm_valid, fm_col, fm_row
  );

  // Environment side (controller, buffer and featuremap bank)
  modport master (
    output start, hold, rd_data, fm_valid_out,
    input  busy, done, err, rd_en, rd_addr, fm_data, fm_valid, fm_col, fm_row
  );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Frame-level sequencer for one convolution layer's featuremap bank.
// Reads an IMG_SIZE x IMG_SIZE frame from the input buffer, streams the
// pixels with row/column tags into the featuremap bank, then counts the
// bank's output strobes until the frame is complete. IMG_SIZE must be
// <= 128 (7-bit tags) and 2**ADDR_WIDTH must cover IMG_SIZE*IMG_SIZE.
module conv_layer_sequencer #(
  parameter int IMG_SIZE   = 104,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 14
) (
  input logic                   clk,
  input logic                   rst_n,
  conv_layer_sequencer_if.slave bus
);

  localparam int                  TOTAL     = IMG_SIZE * IMG_SIZE;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   TOTAL_CNT = (ADDR_WIDTH + 1)'(TOTAL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [6:0]            LAST_POS  = 7'(IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  state_e                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q,   rd_cnt_d;
  logic [ADDR_WIDTH:0]   out_cnt_q,  out_cnt_d;
  logic [6:0]            col_q,      col_d;
  logic [6:0]            row_q,      row_d;
  logic                  fm_valid_q, fm_valid_d;
  logic [6:0]            fm_col_q,   fm_col_d;
  logic [6:0]            fm_row_q,   fm_row_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;

  logic                  rd_en;
  logic                  out_hit;
  logic [DATA_WIDTH-1:0] pixel;

  // hold must stop a read in the same cycle, so the read strobe is decoded
  // from the registered state rather than registered itself.
  assign rd_en   = (state_q == FETCH) && !bus.hold;
  assign out_hit = bus.fm_valid_out && ((state_q == FETCH) || (state_q == DRAIN));

  // Pixel data passes straight through; the buffer already delivers it one
  // cycle after rd_en, aligned with the registered fm_valid.
  assign pixel       = bus.rd_data;
  assign bus.fm_data = pixel;

  // Next-state and counter logic for the whole frame sequence.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // an unassigned path in combinational logic would infer a latch.
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    fm_col_d   = fm_col_q;
    fm_row_d   = fm_row_q;
    err_d      = err_q;
    fm_valid_d = rd_en;

    // Tag the pixel being read and advance the raster position.
    if (rd_en) begin
      fm_col_d = col_q;
      fm_row_d = row_q;
      if (col_q == LAST_POS) begin
        col_d = 7'd0;
        row_d = (row_q == LAST_POS) ? 7'd0 : row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end

    // Output strobes are only expected while a frame is in flight.
    if (out_hit) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
      if (out_cnt_q >= TOTAL_CNT) begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.fm_valid_out) begin
          err_d = 1'b1;
        end
        // An accepted start clears err after the stray-strobe check, so a
        // simultaneous strobe leaves err low.
        if (bus.start) begin
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          col_d     = 7'd0;
          row_d     = 7'd0;
          err_d     = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + ADDR_ONE;
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_cnt_d >= TOTAL_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.fm_valid_out) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Status flags follow the state being entered, so they are registered.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, counters and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      col_q      <= 7'd0;
      row_q      <= 7'd0;
      fm_valid_q <= 1'b0;
      fm_col_q   <= 7'd0;
      fm_row_q   <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fm_valid_q <= fm_valid_d;
      fm_col_q   <= fm_col_d;
      fm_row_q   <= fm_row_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_cnt_q;
  assign bus.fm_valid = fm_valid_q;
  assign bus.fm_col   = fm_col_q;
  assign bus.fm_row   = fm_row_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule
